// File: rtl/switch_debouncer_pkg.sv
// Shared defaults for the switch conditioning block.
package switch_debouncer_pkg;

   localparam int DEFAULT_WIDTH         = 8;
   localparam int DEFAULT_SYNC_STAGES   = 2;
   localparam int DEFAULT_STABLE_CYCLES = 1024;

   // Counter width needed to hold 0..stable_cycles.
   function automatic int cnt_width(input int stable_cycles);
      return $clog2(stable_cycles + 1);
   endfunction

endpackage

// File: rtl/switch_debouncer_if.sv
// Switch-side inputs and conditioned outputs of the debouncer.
interface switch_debouncer_if
   import switch_debouncer_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH
);
   logic             tick;
   logic [WIDTH-1:0] sw_raw;
   logic [WIDTH-1:0] sw_clean;
   logic [WIDTH-1:0] rise;
   logic [WIDTH-1:0] fall;
   logic             changed;

   modport master (
      output tick, sw_raw,
      input  sw_clean, rise, fall, changed
   );

   modport slave (
      input  tick, sw_raw,
      output sw_clean, rise, fall, changed
   );
endinterface

// File: rtl/switch_debouncer_debounce_bit.sv
// One switch bit: synchroniser, stability counter, clean level and edge pulses.
// Accepts a new level after STABLE_CYCLES consecutive ticks of disagreement.
module debounce_bit
   import switch_debouncer_pkg::*;
#(
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input  logic clock,
   input  logic reset_n,
   input  logic tick,
   input  logic raw,
   output logic clean,
   output logic rise,
   output logic fall
);
   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);

   logic [SYNC_STAGES-1:0] sync;
   logic [CW-1:0]          cnt;
   logic                   s;

   assign s = sync[SYNC_STAGES-1];

   always_ff @(posedge clock) begin
      if (!reset_n) begin
         sync  <= '0;
         cnt   <= '0;
         clean <= 1'b0;
         rise  <= 1'b0;
         fall  <= 1'b0;
      end else begin
         sync <= {sync[SYNC_STAGES-2:0], raw};
         rise <= 1'b0;
         fall <= 1'b0;
         // Any return to the accepted level throws away the partial count.
         if (s == clean) begin
            cnt <= '0;
         end else if (tick) begin
            if (cnt == CNT_LAST) begin
               clean <= s;
               cnt   <= '0;
               rise  <= s;
               fall  <= ~s;
            end else begin
               cnt <= cnt + 1'b1;
            end
         end
      end
   end

endmodule

// File: rtl/switch_debouncer.sv
// Debounces WIDTH slide switches in parallel; sw_clean follows a raw step
// SYNC_STAGES+STABLE_CYCLES clocks later with tick held high.
module switch_debouncer
   import switch_debouncer_pkg::*;
#(
   parameter int WIDTH         = DEFAULT_WIDTH,
   parameter int SYNC_STAGES   = DEFAULT_SYNC_STAGES,
   parameter int STABLE_CYCLES = DEFAULT_STABLE_CYCLES
) (
   input logic                clock,
   input logic                reset_n,
   switch_debouncer_if.slave  sw_if
);

   for (genvar i = 0; i < WIDTH; i++) begin : g_bit
      debounce_bit #(
         .SYNC_STAGES   (SYNC_STAGES),
         .STABLE_CYCLES (STABLE_CYCLES)
      ) u_bit (
         .clock   (clock),
         .reset_n (reset_n),
         .tick    (sw_if.tick),
         .raw     (sw_if.sw_raw[i]),
         .clean   (sw_if.sw_clean[i]),
         .rise    (sw_if.rise[i]),
         .fall    (sw_if.fall[i])
      );
   end

   // Built from the registered pulses so it lines up with them.
   assign sw_if.changed = |(sw_if.rise | sw_if.fall);

endmodule

// File: tb/tb_switch_debouncer.sv
module tb_switch_debouncer;

   localparam int W   = 8;
   localparam int LAT = 6;   // SYNC_STAGES + STABLE_CYCLES

   logic clock = 1'b0;
   logic reset_n = 1'b0;
   int   cyc = 0;
   int   checks = 0;
   int   errors = 0;

   typedef struct {
      int           cyc;
      logic [W-1:0] clean;
      logic [W-1:0] rise;
      logic [W-1:0] fall;
   } exp_t;

   exp_t q[$];

   switch_debouncer_if #(.WIDTH(W)) sw_if ();

   switch_debouncer #(
      .WIDTH         (W),
      .SYNC_STAGES   (2),
      .STABLE_CYCLES (4)
   ) dut (
      .clock   (clock),
      .reset_n (reset_n),
      .sw_if   (sw_if)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Called at a negedge after edge cyc; the raw change is first sampled at cyc+1.
   task automatic expect_after(input int lat, input logic [W-1:0] clean,
                               input logic [W-1:0] rise, input logic [W-1:0] fall);
      exp_t e;
      e.cyc   = cyc + lat;
      e.clean = clean;
      e.rise  = rise;
      e.fall  = fall;
      q.push_back(e);
   endtask

   task automatic wait_cycles(input int n);
      repeat (n) @(negedge clock);
   endtask

   // Monitor: every changed pulse must match the next queued expectation.
   always @(negedge clock) begin
      if (sw_if.changed === 1'b1) begin
         if (q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_pulse: rise=%0h fall=%0h with nothing expected (cycle %0d)",
                     sw_if.rise, sw_if.fall, cyc);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("pulse_cycle", cyc, e.cyc);
            chk("sw_clean", {24'd0, sw_if.sw_clean}, {24'd0, e.clean});
            chk("rise", {24'd0, sw_if.rise}, {24'd0, e.rise});
            chk("fall", {24'd0, sw_if.fall}, {24'd0, e.fall});
         end
      end
   end

   initial begin
      sw_if.tick   = 1'b1;
      sw_if.sw_raw = 8'hFF;
      reset_n      = 1'b0;

      // Reset holds everything at zero despite raw all-ones.
      wait_cycles(10);
      chk("reset_sw_clean", {24'd0, sw_if.sw_clean}, 32'd0);
      chk("reset_rise", {24'd0, sw_if.rise}, 32'd0);
      chk("reset_fall", {24'd0, sw_if.fall}, 32'd0);
      chk("reset_changed", {31'd0, sw_if.changed}, 32'd0);
      sw_if.sw_raw = 8'h00;
      reset_n      = 1'b1;
      wait_cycles(4);
      chk("idle_sw_clean", {24'd0, sw_if.sw_clean}, 32'd0);

      // Clean step on bits 0 and 2.
      sw_if.sw_raw = 8'h05;
      expect_after(LAT, 8'h05, 8'h05, 8'h00);
      wait_cycles(LAT + 1);
      chk("step_after_pulse_rise", {24'd0, sw_if.rise}, 32'd0);
      chk("step_level_held", {24'd0, sw_if.sw_clean}, 32'h05);
      wait_cycles(4);

      // Fall back to zero before the bounce test.
      sw_if.sw_raw = 8'h00;
      expect_after(LAT, 8'h00, 8'h00, 8'h05);
      wait_cycles(10);

      // Bounce on bit0: 1,0,1,0 then held at 1.
      sw_if.sw_raw = 8'h01; wait_cycles(1);
      sw_if.sw_raw = 8'h00; wait_cycles(1);
      sw_if.sw_raw = 8'h01; wait_cycles(1);
      sw_if.sw_raw = 8'h00; wait_cycles(1);
      sw_if.sw_raw = 8'h01;
      expect_after(LAT, 8'h01, 8'h01, 8'h00);
      wait_cycles(12);
      chk("bounce_level", {24'd0, sw_if.sw_clean}, 32'h01);

      // Tick every third cycle: s differs from edge 3, ticks at 3,6,9,12.
      sw_if.sw_raw = 8'h81;
      expect_after(12, 8'h81, 8'h80, 8'h00);
      for (int i = 1; i <= 16; i++) begin
         sw_if.tick = (i % 3 == 0);
         wait_cycles(1);
         if (i == 11)
            chk("tick_not_early", {24'd0, sw_if.sw_clean}, 32'h01);
      end
      sw_if.tick = 1'b1;
      wait_cycles(4);

      // Move to 8'h0F, then swap every bit at once.
      sw_if.sw_raw = 8'h0F;
      expect_after(LAT, 8'h0F, 8'h0E, 8'h80);
      wait_cycles(10);
      sw_if.sw_raw = 8'hF0;
      expect_after(LAT, 8'hF0, 8'hF0, 8'h0F);
      wait_cycles(10);
      sw_if.sw_raw = 8'h00;
      expect_after(LAT, 8'h00, 8'h00, 8'hF0);
      wait_cycles(10);

      // Reset at edge 4 of a bit3 step discards the partial count.
      sw_if.sw_raw = 8'h08;
      wait_cycles(3);
      reset_n = 1'b0;
      wait_cycles(2);
      chk("midreset_sw_clean", {24'd0, sw_if.sw_clean}, 32'd0);
      chk("midreset_changed", {31'd0, sw_if.changed}, 32'd0);
      reset_n = 1'b1;
      expect_after(LAT, 8'h08, 8'h08, 8'h00);
      wait_cycles(LAT - 1);
      chk("midreset_not_early", {24'd0, sw_if.sw_clean}, 32'd0);
      wait_cycles(6);
      chk("midreset_final", {24'd0, sw_if.sw_clean}, 32'h08);

      wait_cycles(5);
      chk("scoreboard_drained", q.size(), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
